// File: rtl/ir_fusion_pkg.sv
// Shared types and width helpers for the IR/gyro heading-fusion block.
package ir_fusion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CALC
  } fusion_state_e;

  // Encoded as {lft_opn, rght_opn} so the mode can be cast straight from the flags.
  typedef enum logic [1:0] {
    BOTH_CLOSED = 2'b00,
    LFT_OPN     = 2'b10,
    RGHT_OPN    = 2'b01,
    BOTH_OPN    = 2'b11
  } open_mode_e;

  localparam int unsigned DTRM_W = 9;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_avg_accum.sv
// Per-sample IR error selection and averaging accumulator with open-mode restart.
// Emits the averaged error and a one-cycle done strobe while in CALC.
module ir_avg_accum
  import ir_fusion_pkg::*;
#(
  parameter int unsigned    IR_W     = 12,
  parameter logic [IR_W-1:0] NOM_IR  = 12'h370,
  parameter int unsigned    AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   IR_vld,
  input  logic signed [IR_W-1:0] lft_IR,
  input  logic signed [IR_W-1:0] rght_IR,
  input  logic                   lft_opn,
  input  logic                   rght_opn,
  output logic signed [IR_W:0]   avg,
  output logic                   done
);

  localparam int unsigned ACC_W = IR_W + 1 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] NSAMP = CNT_W'(1 << AVG_LOG2);

  fusion_state_e state_q, state_d;
  open_mode_e    mode_q, mode_d, mode_in;
  logic signed [ACC_W-1:0] acc_q, acc_d, e_x;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic signed [IR_W:0] lft_x, rght_x, nom_x, diff, e;

  assign mode_in = open_mode_e'({lft_opn, rght_opn});
  assign lft_x   = {lft_IR[IR_W-1], lft_IR};
  assign rght_x  = {rght_IR[IR_W-1], rght_IR};
  assign nom_x   = {NOM_IR[IR_W-1], NOM_IR};
  assign diff    = lft_x - rght_x;

  always_comb begin
    e = '0;
    unique case (mode_in)
      BOTH_CLOSED: e = diff >>> 1;
      LFT_OPN:     e = nom_x - rght_x;
      RGHT_OPN:    e = lft_x - nom_x;
      BOTH_OPN:    e = '0;
      default:     e = '0;
    endcase
  end

  assign e_x     = ACC_W'(e);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      mode_d  = BOTH_CLOSED;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (IR_vld) begin
            acc_d   = e_x;
            cnt_d   = CNT_W'(1);
            mode_d  = mode_in;
            state_d = (AVG_LOG2 == 0) ? CALC : ACCUM;
          end
        end
        ACCUM: begin
          if (IR_vld) begin
            if (mode_in != mode_q) begin
              // A wall appeared or vanished: the partial set is discarded.
              acc_d  = e_x;
              cnt_d  = CNT_W'(1);
              mode_d = mode_in;
            end else begin
              acc_d = acc_q + e_x;
              cnt_d = cnt_inc;
              if (cnt_inc == NSAMP) state_d = CALC;
            end
          end
        end
        CALC:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= BOTH_CLOSED;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // The average of IR_W+1-bit samples always fits back into IR_W+1 bits.
  assign avg  = acc_q[AVG_LOG2 +: IR_W+1];
  assign done = (state_q == CALC);

endmodule

// File: rtl/ir_hdng_fusion.sv
// IR/gyro heading fusion: averaged IR error feeds a saturated PD correction that
// is added to the desired heading. Define IR_HDNG_FUSION_SLEW_EN to slew-limit it.
module ir_hdng_fusion
  import ir_fusion_pkg::*;
#(
  parameter int unsigned     IR_W      = 12,
  parameter int unsigned     HDNG_W    = 12,
  parameter logic [IR_W-1:0] NOM_IR    = 12'h370,
  parameter int unsigned     AVG_LOG2  = 2,
  parameter int unsigned     P_SHIFT   = 5,
  parameter int unsigned     D_SHIFT   = 2,
  parameter int unsigned     CORR_LIM  = 1023,
  parameter int unsigned     SLEW_STEP = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     IR_vld,
  input  logic signed [IR_W-1:0]   lft_IR,
  input  logic signed [IR_W-1:0]   rght_IR,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic signed [DTRM_W-1:0] IR_Dtrm,
  input  logic                     en_fusion,
  input  logic [HDNG_W-1:0]        dsrd_hdng,
  output logic [HDNG_W-1:0]        dsrd_hdng_adj,
  output logic                     adj_vld,
  output logic                     corr_sat
);

  localparam int unsigned PD_W  = max_w(IR_W + 1, DTRM_W + D_SHIFT) + 1;
  localparam int unsigned SUM_W = max_w(PD_W, HDNG_W);
  localparam logic signed [PD_W-1:0] LimPos = PD_W'(CORR_LIM);
  localparam logic signed [PD_W-1:0] LimNeg = -LimPos;

  logic signed [IR_W:0]   avg, p_avg;
  logic                   done;
  logic signed [PD_W-1:0] p_x, d_x, pd, pd_sat, tgt, corr_nxt, corr_q;
  logic                   sat;
  logic [HDNG_W-1:0]      corr_h, hdng_adj_q;
  logic                   adj_vld_q, corr_sat_q;

  ir_avg_accum #(
    .IR_W     (IR_W),
    .NOM_IR   (NOM_IR),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_fusion),
    .IR_vld   (IR_vld),
    .lft_IR   (lft_IR),
    .rght_IR  (rght_IR),
    .lft_opn  (lft_opn),
    .rght_opn (rght_opn),
    .avg      (avg),
    .done     (done)
  );

  always_comb begin
    p_avg  = avg >>> P_SHIFT;
    p_x    = PD_W'(p_avg);
    d_x    = PD_W'(IR_Dtrm) <<< D_SHIFT;
    pd     = p_x + d_x;
    pd_sat = pd;
    sat    = 1'b0;
    if (pd > LimPos) begin
      pd_sat = LimPos;
      sat    = 1'b1;
    end else if (pd < LimNeg) begin
      pd_sat = LimNeg;
      sat    = 1'b1;
    end
    tgt = pd_sat >>> 1;
  end

`ifdef IR_HDNG_FUSION_SLEW_EN
  localparam int unsigned DW = PD_W + 1;
  localparam logic signed [DW-1:0] StepP = DW'(SLEW_STEP);
  logic signed [DW-1:0] delta;

  always_comb begin
    delta    = DW'(tgt) - DW'(corr_q);
    corr_nxt = tgt;
    if (delta > StepP) begin
      corr_nxt = corr_q + PD_W'(SLEW_STEP);
    end else if (delta < -StepP) begin
      corr_nxt = corr_q - PD_W'(SLEW_STEP);
    end
  end
`else
  assign corr_nxt = tgt;
`endif

  // Sign-extend (or truncate) the correction onto the circular heading.
  assign corr_h = HDNG_W'(SUM_W'(corr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q     <= '0;
      corr_sat_q <= 1'b0;
      adj_vld_q  <= 1'b0;
      hdng_adj_q <= '0;
    end else begin
      adj_vld_q <= en_fusion & done;
      if (!en_fusion) begin
        corr_q     <= '0;
        corr_sat_q <= 1'b0;
      end else if (done) begin
        corr_q     <= corr_nxt;
        corr_sat_q <= sat;
      end
      hdng_adj_q <= en_fusion ? (dsrd_hdng + corr_h) : dsrd_hdng;
    end
  end

  assign dsrd_hdng_adj = hdng_adj_q;
  assign adj_vld       = adj_vld_q;
  assign corr_sat      = corr_sat_q;

endmodule
